// File: rtl/ifid_field_stage_pkg.sv
// Shared definitions for the IF/ID field stage: instruction field positions,
// state encodings and the decoded-field bundle handed to decode.
package ifid_field_stage_pkg;

    localparam int INSTR_W = 32;
    localparam int OPC_W   = 6;
    localparam int REG_W   = 5;
    localparam int SHAMT_W = 5;
    localparam int FUNCT_W = 6;
    localparam int IMM_W   = 16;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int SH_HI  = 10;
    localparam int SH_LO  = 6;
    localparam int FN_HI  = 5;
    localparam int FN_LO  = 0;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    localparam logic [OPC_W-1:0] LUI_OPCODE_DEF = 6'h0F;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    typedef struct packed {
        logic [OPC_W-1:0]   opcode;
        logic [REG_W-1:0]   rs;
        logic [REG_W-1:0]   rt;
        logic [REG_W-1:0]   rd;
        logic [SHAMT_W-1:0] shamt;
        logic [FUNCT_W-1:0] funct;
        logic [IMM_W-1:0]   immed;
        logic [INSTR_W-1:0] sext_imm;
        logic               is_lui;
    } instr_fields_t;

    function automatic logic [INSTR_W-1:0] sext16(input logic [IMM_W-1:0] imm);
        return {{(INSTR_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/ifid_field_stage_if.sv
// Fetch-side and decode-side handshake bundle of the IF/ID field stage.
interface ifid_field_stage_if
    import ifid_field_stage_pkg::*;
#(
    parameter int PC_W = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [PC_W-1:0]      in_pc;
    logic [INSTR_W-1:0]   in_instr;
    logic                 out_valid;
    logic                 out_ready;
    logic [PC_W-1:0]      out_pc;
    logic [OPC_W-1:0]     out_opcode;
    logic [REG_W-1:0]     out_rs;
    logic [REG_W-1:0]     out_rt;
    logic [REG_W-1:0]     out_rd;
    logic [SHAMT_W-1:0]   out_shamt;
    logic [FUNCT_W-1:0]   out_funct;
    logic [IMM_W-1:0]     out_immed;
    logic [INSTR_W-1:0]   out_sext_imm;
    logic                 out_is_lui;

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rs, out_rt, out_rd,
               out_shamt, out_funct, out_immed, out_sext_imm, out_is_lui
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rs, out_rt, out_rd,
               out_shamt, out_funct, out_immed, out_sext_imm, out_is_lui
    );
endinterface

// File: rtl/ifid_field_stage_instr_field_split.sv
// Combinational split of a 32-bit instruction into its fields; kept separate
// so later decode stages can reuse it.
module instr_field_split
    import ifid_field_stage_pkg::*;
#(
    parameter logic [OPC_W-1:0] LUI_OPCODE = LUI_OPCODE_DEF
) (
    input  logic               valid,
    input  logic [INSTR_W-1:0] instr,
    output instr_fields_t      fields
);
    assign fields.opcode   = instr[OPC_HI:OPC_LO];
    assign fields.rs       = instr[RS_HI:RS_LO];
    assign fields.rt       = instr[RT_HI:RT_LO];
    assign fields.rd       = instr[RD_HI:RD_LO];
    assign fields.shamt    = instr[SH_HI:SH_LO];
    assign fields.funct    = instr[FN_HI:FN_LO];
    assign fields.immed    = instr[IMM_HI:IMM_LO];
    assign fields.sext_imm = sext16(instr[IMM_HI:IMM_LO]);
    // Gated by valid so a stale register image never looks like a LUI.
    assign fields.is_lui   = valid && (instr[OPC_HI:OPC_LO] == LUI_OPCODE);
endmodule

// File: rtl/ifid_field_stage.sv
// IF/ID stage: 2-entry skid buffer holding {pc, instr}; ready/valid both come
// straight from the state register, fields are sliced from the head word.
module ifid_field_stage
    import ifid_field_stage_pkg::*;
#(
    parameter int               PC_W       = 32,
    parameter logic [OPC_W-1:0] LUI_OPCODE = LUI_OPCODE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    ifid_field_stage_if.slave bus
);
    localparam int WORD_W = PC_W + INSTR_W;

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [WORD_W-1:0] main_r;
    logic [WORD_W-1:0] skid_r;
    logic [WORD_W-1:0] in_word_s;
    logic              in_ready_s;
    logic              out_valid_s;
    logic              in_fire_s;
    logic              out_fire_s;
    logic              load_main_s;
    logic              load_skid_s;
    logic              main_from_skid_s;
    instr_fields_t     fields_s;

    assign in_ready_s  = (state_r != ST_SKID);
    assign out_valid_s = (state_r != ST_EMPTY);
    assign in_fire_s   = bus.in_valid && in_ready_s;
    assign out_fire_s  = out_valid_s && bus.out_ready;
    assign in_word_s   = {bus.in_pc, bus.in_instr};

    // Next-state and register-load decisions; flush overrides everything.
    always_comb begin
        state_nxt_s      = state_r;
        load_main_s      = 1'b0;
        load_skid_s      = 1'b0;
        main_from_skid_s = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (in_fire_s) begin
                    load_main_s = 1'b1;
                    state_nxt_s = ST_FULL;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (in_fire_s && out_fire_s) begin
                    load_main_s = 1'b1;
                    state_nxt_s = ST_FULL;
                end else if (in_fire_s) begin
                    load_skid_s = 1'b1;
                    state_nxt_s = ST_SKID;
                end else if (out_fire_s) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            ST_SKID: begin
                if (out_fire_s) begin
                    load_main_s      = 1'b1;
                    main_from_skid_s = 1'b1;
                    state_nxt_s      = ST_FULL;
                end else begin
                    state_nxt_s = ST_SKID;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
        if (flush) begin
            state_nxt_s      = ST_EMPTY;
            load_main_s      = 1'b0;
            load_skid_s      = 1'b0;
            main_from_skid_s = 1'b0;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Data registers move only on a transfer and otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_r <= {WORD_W{1'b0}};
            skid_r <= {WORD_W{1'b0}};
        end else begin
            if (load_main_s) begin
                main_r <= main_from_skid_s ? skid_r : in_word_s;
            end
            if (load_skid_s) begin
                skid_r <= in_word_s;
            end
        end
    end

    instr_field_split #(
        .LUI_OPCODE (LUI_OPCODE)
    ) u_split (
        .valid  (out_valid_s),
        .instr  (main_r[INSTR_W-1:0]),
        .fields (fields_s)
    );

    assign bus.in_ready     = in_ready_s;
    assign bus.out_valid    = out_valid_s;
    assign bus.out_pc       = main_r[WORD_W-1:INSTR_W];
    assign bus.out_opcode   = fields_s.opcode;
    assign bus.out_rs       = fields_s.rs;
    assign bus.out_rt       = fields_s.rt;
    assign bus.out_rd       = fields_s.rd;
    assign bus.out_shamt    = fields_s.shamt;
    assign bus.out_funct    = fields_s.funct;
    assign bus.out_immed    = fields_s.immed;
    assign bus.out_sext_imm = fields_s.sext_imm;
    assign bus.out_is_lui   = fields_s.is_lui;

endmodule

// File: tb/tb_ifid_field_stage.sv
// Directed and randomized self-checking bench for ifid_field_stage.
module tb_ifid_field_stage;

    logic clk;
    logic rst_n;
    logic flush;

    ifid_field_stage_if #(.PC_W(32)) bus();

    ifid_field_stage #(.PC_W(32), .LUI_OPCODE(6'h0F)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [112:0] outv();
        return {bus.out_pc, bus.out_opcode, bus.out_rs, bus.out_rt, bus.out_rd,
                bus.out_shamt, bus.out_funct, bus.out_immed, bus.out_sext_imm,
                bus.out_is_lui};
    endfunction

    function automatic logic [112:0] expv(input logic [31:0] pc, input logic [31:0] instr);
        logic is_lui;
        is_lui = (instr[31:26] == 6'h0F);
        return {pc, instr, instr[15:0], {{16{instr[15]}}, instr[15:0]}, is_lui};
    endfunction

    logic [63:0]  q[$];
    logic [63:0]  head;
    logic [112:0] snap;
    logic         stalled;
    logic         in_fire_last;
    int           sent;
    int           rcvd;
    int           cycles;

    initial begin
        rst_n        = 1'b0;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_pc    = 32'h0;
        bus.in_instr = 32'h0;
        bus.out_ready = 1'b0;

        // Reset
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_fields", outv(), 113'h0);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rel_out_valid", bus.out_valid, 1'b0);
        check("rel_in_ready", bus.in_ready, 1'b1);

        // LUI word
        bus.in_valid = 1'b1; bus.in_instr = 32'h3C0815B5; bus.in_pc = 32'h40; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("lui_valid", bus.out_valid, 1'b1);
        check("lui_is_lui", bus.out_is_lui, 1'b1);
        check("lui_rt", bus.out_rt, 5'd8);
        check("lui_immed", bus.out_immed, 16'h15B5);
        check("lui_sext", bus.out_sext_imm, 32'h0000_15B5);
        check("lui_pc", bus.out_pc, 32'h40);
        check("lui_rd_shamt_funct", {bus.out_rd, bus.out_shamt, bus.out_funct}, {5'd2, 5'd22, 6'h35});
        @(negedge clk);
        check("lui_drain", bus.out_valid, 1'b0);

        // Stall and skid
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_instr = 32'h2009FFFF; bus.in_pc = 32'h44;
        @(negedge clk);
        check("stall_ready1", bus.in_ready, 1'b1);
        check("stall_sext1", bus.out_sext_imm, 32'hFFFF_FFFF);
        bus.in_instr = 32'h3C0A8001; bus.in_pc = 32'h48;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("skid_ready0", bus.in_ready, 1'b0);
        check("skid_head", outv(), expv(32'h44, 32'h2009FFFF));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("skid_hold", outv(), expv(32'h44, 32'h2009FFFF));
            check("skid_hold_ready", bus.in_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("skid_second", outv(), expv(32'h48, 32'h3C0A8001));
        check("skid_second_immed", bus.out_immed, 16'h8001);
        check("skid_ready_back", bus.in_ready, 1'b1);
        @(negedge clk);
        check("skid_drain", bus.out_valid, 1'b0);

        // Back-to-back stream
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                check("b2b_valid", bus.out_valid, 1'b1);
                check("b2b_word", outv(), expv(32'h100 + 32'(4 * (i - 1)), 32'h2000_0000 | 32'(i - 1)));
            end
            check("b2b_in_ready", bus.in_ready, 1'b1);
            if (i < 8) begin
                bus.in_valid = 1'b1; bus.in_instr = 32'h2000_0000 | 32'(i); bus.in_pc = 32'h100 + 32'(4 * i);
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b_drain", bus.out_valid, 1'b0);

        // Flush in SKID with an input word pending
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_instr = 32'h11111111; bus.in_pc = 32'h200;
        @(negedge clk);
        bus.in_instr = 32'h22222222; bus.in_pc = 32'h204;
        @(negedge clk);
        check("fl_skid_state", bus.in_ready, 1'b0);
        bus.in_instr = 32'h33333333; bus.in_pc = 32'h208; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; bus.in_valid = 1'b0;
        check("fl_skid_valid", bus.out_valid, 1'b0);
        check("fl_skid_ready", bus.in_ready, 1'b1);

        // Flush in FULL while an input would have been accepted
        bus.in_valid = 1'b1; bus.in_instr = 32'h44444444; bus.in_pc = 32'h20C;
        @(negedge clk);
        bus.in_instr = 32'h55555555; bus.in_pc = 32'h210; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fl_full_valid", bus.out_valid, 1'b0);
        bus.in_instr = 32'h66666666; bus.in_pc = 32'h214; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("fl_next_word", outv(), expv(32'h214, 32'h66666666));
        @(negedge clk);
        check("fl_drain", bus.out_valid, 1'b0);

        // Asynchronous reset while holding a word
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_instr = 32'h77777777; bus.in_pc = 32'h300;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("ar_loaded", bus.out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", bus.out_valid, 1'b0);
        check("ar_ready", bus.in_ready, 1'b1);
        check("ar_fields", outv(), 113'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Random traffic with scoreboard and hold check
        sent = 0; rcvd = 0; cycles = 0; stalled = 1'b0; in_fire_last = 1'b0; snap = '0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        while (rcvd < 1000 && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            if (stalled) check("rnd_hold", outv(), snap);
            if (in_fire_last) bus.in_valid = 1'b0;
            if (!bus.in_valid && sent < 1000 && $urandom_range(0, 9) < 7) begin
                bus.in_pc    = $urandom;
                bus.in_instr = $urandom;
                if ($urandom_range(0, 7) == 0) bus.in_instr[31:26] = 6'h0F;
                bus.in_valid = 1'b1;
            end
            bus.out_ready = ($urandom_range(0, 9) < 6);
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() > 0) begin
                    head = q.pop_front();
                    check("rnd_word", outv(), expv(head[63:32], head[31:0]));
                end else begin
                    check("rnd_unexpected_out", bus.out_valid, 1'b0);
                end
                rcvd++;
            end
            in_fire_last = bus.in_valid && bus.in_ready;
            if (in_fire_last) begin
                q.push_back({bus.in_pc, bus.in_instr});
                sent++;
            end
            stalled = bus.out_valid && !bus.out_ready;
            snap    = outv();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        check("rnd_count", 128'(rcvd), 128'd1000);
        check("rnd_queue_empty", 128'(q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
